// File: rtl/sdram_stream_reader.sv
// SDRAM frame reader: power-up init, then streams WORDS_TO_LOAD words as auto-precharge bursts.
// Optional periodic refresh is built when SDRAM_REFRESH_EN is defined.
module sdram_stream_reader #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned ROW_W          = 13,
  parameter int unsigned COL_W          = 10,
  parameter int unsigned BANK_W         = 2,
  parameter int unsigned BURST_LEN      = 8,
  parameter int unsigned CAS_LAT        = 2,
  parameter int unsigned WORDS_TO_LOAD  = 76800,
  parameter int unsigned INIT_CYCLES    = 14300,
  parameter int unsigned REFRESH_CYCLES = 1100,
  parameter int unsigned T_RCD          = 3,
  parameter int unsigned T_RP           = 3,
  parameter int unsigned T_RC           = 9
) (
  input  logic                            ck143,
  input  logic                            reset,
  inout  wire logic [DATA_W-1:0]          mem_dq,
  output logic [ROW_W-1:0]                mem_a,
  output logic [BANK_W-1:0]               mem_ba,
  output logic                            mem_cke,
  output logic                            mem_ldqm,
  output logic                            mem_udqm,
  output logic                            mem_cs_n,
  output logic                            mem_ras_n,
  output logic                            mem_cas_n,
  output logic                            mem_we_n,
  input  logic                            start,
  input  logic [ROW_W+BANK_W+COL_W-1:0]   base_addr,
  input  logic                            pause,
  output logic [DATA_W-1:0]               data_out,
  output logic                            data_valid,
  output logic                            frame_done,
  output logic                            busy
);

  localparam int unsigned ADDR_W = ROW_W + BANK_W + COL_W;
  localparam int unsigned BW_CYC = CAS_LAT + BURST_LEN + T_RP;
  localparam int unsigned MAX_A  = (INIT_CYCLES > BW_CYC) ? INIT_CYCLES : BW_CYC;
  localparam int unsigned MAX_B  = (MAX_A > T_RC) ? MAX_A : T_RC;
  localparam int unsigned MAX_C  = (MAX_B > T_RP) ? MAX_B : T_RP;
  localparam int unsigned MAX_D  = (MAX_C > T_RCD) ? MAX_C : T_RCD;
  localparam int unsigned CNT_W  = $clog2(MAX_D + 2);
  localparam int unsigned WC_W   = $clog2(WORDS_TO_LOAD + 1);
  localparam int unsigned MRS_V  = $clog2(BURST_LEN) + CAS_LAT * 16;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;

  localparam logic [ROW_W-1:0] A10 = ROW_W'(1024);

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF, S_INIT_MRS,
    S_IDLE, S_REF, S_ACT, S_BURST
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ref_num;
  logic [3:0]          r_cmd;
  logic [ROW_W-1:0]    r_a;
  logic [BANK_W-1:0]   r_ba;
  logic                r_dqm;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_data_valid;
  logic                r_frame_done;
  logic                r_busy;
  logic                r_frame_active;
  logic [ADDR_W-1:0]   r_base;
  logic [WC_W-1:0]     r_word_cnt;

  logic [ADDR_W-1:0]   w_addr;
  logic [COL_W-1:0]    w_col;
  logic [BANK_W-1:0]   w_bank;
  logic [ROW_W-1:0]    w_row;
  logic                w_last;
  logic                w_ref_due;
  logic                w_ref_issue;

  assign mem_dq     = {DATA_W{1'bz}};
  assign mem_cke    = 1'b1;
  assign {mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n} = r_cmd;
  assign mem_a      = r_a;
  assign mem_ba     = r_ba;
  assign mem_ldqm   = r_dqm;
  assign mem_udqm   = r_dqm;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

  // Linear word address split as {row, bank, column}
  assign w_addr = r_base + ADDR_W'(r_word_cnt);
  assign w_col  = w_addr[COL_W-1:0];
  assign w_bank = w_addr[COL_W +: BANK_W];
  assign w_row  = w_addr[COL_W+BANK_W +: ROW_W];
  assign w_last = (32'(r_word_cnt) + 32'(BURST_LEN)) == 32'(WORDS_TO_LOAD);

  assign w_ref_issue = (r_state == S_IDLE) && w_ref_due;

`ifdef SDRAM_REFRESH_EN
  localparam int unsigned RT_W = $clog2(REFRESH_CYCLES + 1);
  logic [RT_W-1:0] r_ref_timer;
  logic            r_ref_pending;

  // Free-running interval timer; an expiry while already pending is dropped
  always_ff @(posedge ck143) begin
    if (reset) begin
      r_ref_timer   <= '0;
      r_ref_pending <= 1'b0;
    end else if (r_ref_timer == RT_W'(REFRESH_CYCLES - 1)) begin
      r_ref_timer   <= '0;
      r_ref_pending <= 1'b1;
    end else begin
      r_ref_timer <= r_ref_timer + RT_W'(1);
      if (w_ref_issue) r_ref_pending <= 1'b0;
    end
  end

  assign w_ref_due = r_ref_pending;
`else
  // Interval is meaningless without the timer; the term folds to constant 0
  assign w_ref_due = 1'b0 & (REFRESH_CYCLES == 0);
`endif

  always_ff @(posedge ck143) begin
    if (reset) begin
      r_state        <= S_INIT_WAIT;
      r_cnt          <= '0;
      r_ref_num      <= 1'b0;
      r_cmd          <= CMD_NOP;
      r_a            <= '0;
      r_ba           <= '0;
      r_dqm          <= 1'b1;
      r_data_out     <= '0;
      r_data_valid   <= 1'b0;
      r_frame_done   <= 1'b0;
      r_busy         <= 1'b1;
      r_frame_active <= 1'b0;
      r_base         <= '0;
      r_word_cnt     <= '0;
    end else begin
      r_cmd        <= CMD_NOP;
      r_data_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_cnt        <= r_cnt + CNT_W'(1);
      case (r_state)
        S_INIT_WAIT: if (r_cnt == CNT_W'(INIT_CYCLES)) begin
          r_cmd   <= CMD_PRE;
          r_a     <= A10;
          r_cnt   <= '0;
          r_state <= S_INIT_PRE;
        end
        S_INIT_PRE: if (r_cnt == CNT_W'(T_RP)) begin
          r_cmd   <= CMD_REF;
          r_cnt   <= '0;
          r_state <= S_INIT_REF;
        end
        S_INIT_REF: if (r_cnt == CNT_W'(T_RC)) begin
          r_cnt <= '0;
          if (!r_ref_num) begin
            r_cmd     <= CMD_REF;
            r_ref_num <= 1'b1;
          end else begin
            r_cmd   <= CMD_MRS;
            r_a     <= ROW_W'(MRS_V);
            r_ba    <= '0;
            r_dqm   <= 1'b0;
            r_state <= S_INIT_MRS;
          end
        end
        S_INIT_MRS: if (r_cnt == CNT_W'(1)) begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_IDLE: begin
          r_cnt <= '0;
          if (start && !r_frame_active) begin
            r_frame_active <= 1'b1;
            r_busy         <= 1'b1;
            r_base         <= base_addr;
            r_word_cnt     <= '0;
          end
          // Pending refresh beats a burst; the burst goes on the next IDLE pass
          if (w_ref_issue) begin
            r_cmd   <= CMD_REF;
            r_state <= S_REF;
          end else if (r_frame_active && !pause) begin
            r_cmd   <= CMD_ACT;
            r_a     <= w_row;
            r_ba    <= w_bank;
            r_state <= S_ACT;
          end
        end
        S_REF: if (r_cnt == CNT_W'(T_RC - 1)) begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        S_ACT: if (r_cnt == CNT_W'(T_RCD - 1)) begin
          r_cmd   <= CMD_RD;
          r_a     <= A10 | ROW_W'(w_col);
          r_ba    <= w_bank;
          r_cnt   <= '0;
          r_state <= S_BURST;
        end
        S_BURST: begin
          // Words land on mem_dq CAS_LAT clocks after the device samples READ
          if (r_cnt >= CNT_W'(CAS_LAT) && r_cnt < CNT_W'(CAS_LAT + BURST_LEN)) begin
            r_data_out   <= mem_dq;
            r_data_valid <= 1'b1;
          end
          if (r_cnt == CNT_W'(CAS_LAT + BURST_LEN) && w_last) r_frame_done <= 1'b1;
          if (r_cnt == CNT_W'(BW_CYC - 1)) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            if (w_last) begin
              r_word_cnt     <= '0;
              r_frame_active <= 1'b0;
              r_busy         <= 1'b0;
            end else begin
              r_word_cnt <= r_word_cnt + WC_W'(BURST_LEN);
            end
          end
        end
        default: r_state <= S_INIT_WAIT;
      endcase
    end
  end

endmodule

// File: doc/sdram_stream_reader.md
Name: sdram_stream_reader

Overview:
- Parametrised next-generation SDRAM read controller for the frame loader. Runs the full power-up sequence: init wait, precharge-all, two auto-refreshes, mode-register set.
- Then streams WORDS_TO_LOAD consecutive words from a base address as fixed-length auto-precharge bursts into the pixel output path.
- Downstream back-pressure is accepted between bursts only.
- Sits between the SDRAM pins and the display line buffer.

Parameters:
- DATA_W, 16, SDRAM data width
- ROW_W, 13, row address width (mem_a width)
- COL_W, 10, column address width
- BANK_W, 2, bank address width
- BURST_LEN, 8, words per burst; legal values 1, 2, 4, 8
- CAS_LAT, 2, CAS latency in clocks; legal values 2, 3
- WORDS_TO_LOAD, 76800, words per frame; must be a multiple of BURST_LEN
- INIT_CYCLES, 14300, power-up NOP wait (100 us at 143 MHz)
- REFRESH_CYCLES, 1100, refresh interval in clocks (7.7 us)
- T_RCD, 3, ACTIVATE-to-READ clocks
- T_RP, 3, precharge clocks
- T_RC, 9, refresh or activate recovery clocks

Ports:
- ck143  in  1  system and SDRAM clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- mem_dq  inout  DATA_W  SDRAM data; always driven Z (read-only block)
- mem_a  out  ROW_W  SDRAM address
- mem_ba  out  BANK_W  SDRAM bank
- mem_cke  out  1  clock enable
- mem_ldqm, mem_udqm  out  1 each  byte masks
- mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n  out  1 each  command pins
- start  in  1  one-cycle pulse; begin a frame load from base_addr
- base_addr  in  ROW_W+BANK_W+COL_W  word address, BURST_LEN-aligned; latched on accepted start
- pause  in  1  level; 1 = downstream cannot take another burst
- data_out  out  DATA_W  read word
- data_valid  out  1  data_out valid this cycle
- frame_done  out  1  one-cycle pulse after the last word of a frame
- busy  out  1  high during init or an active frame

Behaviour:
- Reset values:
  - cke=1; NOP command (cs_n=0, ras_n=cas_n=we_n=1); mem_a=0, mem_ba=0; ldqm=udqm=1.
  - data_out=0, data_valid=0, frame_done=0, busy=1; state=INIT_WAIT, all counters 0.
- Reset asserted in any state, including mid-burst, aborts immediately. The full init sequence then restarts, including INIT_CYCLES.
- Init path:
  - INIT_WAIT: INIT_CYCLES NOPs.
  - INIT_PRE: PRECHARGE with A10=1, then T_RP NOPs.
  - INIT_REF: 2 AUTO REFRESH commands, each followed by T_RC NOPs.
  - INIT_MRS: mode register set with A[2:0]=log2(BURST_LEN), A3=0 (sequential), A[6:4]=CAS_LAT, all other bits 0; 2 NOPs. dqm goes to 0. Then IDLE with busy=0.
- Address split of linear word address: column = low COL_W bits, then bank (BANK_W), then row (ROW_W).
- Bursts never cross a row, given alignment and the WORDS_TO_LOAD rule.
- IDLE:
  - Refresh pending has top priority: REFRESH, then T_RC NOPs.
  - Otherwise, if a frame is active and pause=0: go to ACTIVATE.
  - start is accepted only in IDLE with no frame active. It sets busy=1, latches base_addr and clears word_cnt.
  - start in any other state is ignored.
- ACTIVATE: ACTIVATE(bank,row), then T_RCD-1 NOPs.
- READ: READ with A10=1 (auto-precharge) and the column on mem_a.
- BURST_WAIT: CAS_LAT+BURST_LEN+T_RP NOPs, then word_cnt += BURST_LEN and return to IDLE.
- Data timing:
  - mem_dq is registered into data_out.
  - data_valid is high for BURST_LEN consecutive cycles, starting CAS_LAT+1 cycles after the READ clock edge.
- pause is sampled only in IDLE. A burst that has been issued always completes, so downstream must hold BURST_LEN free slots when it drops pause.
- Frame end:
  - When word_cnt reaches WORDS_TO_LOAD, frame_done pulses for 1 cycle, aligned with the cycle after the last data_valid.
  - busy then falls, and word_cnt wraps to 0.
- Simultaneous refresh-due and burst request in IDLE: refresh wins; the burst follows.

Optional Feature:
- Macro: SDRAM_REFRESH_EN.
- Defined:
  - A free-running counter raises refresh_pending every REFRESH_CYCLES clocks.
  - The flag is cleared when REFRESH is issued. A second expiry while still pending is not queued.
- Undefined:
  - No refresh counter and no periodic REFRESH; only the two init refreshes remain.
  - For short-retention test builds only.

Test Plan:
- Init trace: reset 1 cycle, INIT_CYCLES=20, T_RP=3, T_RC=9 -> 20 NOPs, PRECHARGE (A10=1), 3 NOPs, REFRESH, 9 NOPs, REFRESH, 9 NOPs, MRS with mem_a=13'h023; then busy=0.
- Frame: WORDS_TO_LOAD=32, BURST_LEN=8, base 0x000040 -> 4 bursts at columns 0x40, 0x48, 0x50, 0x58 in bank 0, row 0; 32 data_valid cycles; data_out equals model words; frame_done pulses once.
- Pause: hold pause=1 from before the 2nd READ for 50 cycles -> no ACTIVATE during pause; first burst delivers all 8 words; resumes within 1 cycle of pause falling.
- Refresh (SDRAM_REFRESH_EN, REFRESH_CYCLES=40) -> REFRESH appears only in IDLE, never inside ACTIVATE..BURST_WAIT; at least 1 per 40 cycles over 500 cycles; no word lost.
- Reset mid-burst: assert reset on the 3rd data_valid -> next cycle data_valid=0, NOP on pins, busy=1; full init replays.
- start while busy: second start mid-frame -> ignored; base_addr change has no effect; word count stays 32.
